multi_stage_controller: RTL

MULTI_STAGE_CONTROLLER -- requirements
Module: multi_stage_controller

---
 rtl/multi_stage_controller_if.sv | 40 ++++
 rtl/multi_stage_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multi_stage_controller_if.sv
// Stage controller bus: enemy/player status in, stage state and spawn pulses out.
// master drives the game inputs, slave is the controller.
interface multi_stage_controller_if #(
  parameter int FLY_COUNT      = 4,
  parameter int MOSQUITO_COUNT = 12
);
  logic                      start;
  logic                      player_alive;
  logic [FLY_COUNT-1:0]      fly_alive;
  logic [MOSQUITO_COUNT-1:0] mosquito_alive;
  logic                      spider_alive;
  logic [2:0]                stage_state;
  logic [3:0]                level;
  logic                      wave_spawn;
  logic                      boss_spawn;

  modport master (
    output start,
    output player_alive,
    output fly_alive,
    output mosquito_alive,
    output spider_alive,
    input  stage_state,
    input  level,
    input  wave_spawn,
    input  boss_spawn
  );

  modport slave (
    input  start,
    input  player_alive,
    input  fly_alive,
    input  mosquito_alive,
    input  spider_alive,
    output stage_state,
    output level,
    output wave_spawn,
    output boss_spawn
  );
endinterface

// File: rtl/multi_stage_controller.sv
// Game stage sequencer: normal waves, spider boss, timed clear, game over.
// Every output is a register; spawn pulses last exactly one cycle.
module multi_stage_controller #(
  parameter int FLY_COUNT      = 4,
  parameter int MOSQUITO_COUNT = 12,
  parameter int NUM_LEVELS     = 3,
  parameter int SPAWN_GUARD    = 1,
  parameter int CLEAR_TICKS    = 50_000_000
) (
  input logic                     clk25,
  input logic                     reset,
  multi_stage_controller_if.slave bus
);

  localparam int CW = $clog2(CLEAR_TICKS);
  localparam int GW = $clog2(SPAWN_GUARD + 1);

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_NORMAL   = 3'd1;
  localparam logic [2:0] ST_BOSS     = 3'd2;
  localparam logic [2:0] ST_CLEAR    = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;

  localparam logic [CW-1:0] CLR_LAST   = CW'(CLEAR_TICKS - 1);
  localparam logic [GW-1:0] GUARD_MAX  = GW'(SPAWN_GUARD);
  localparam logic [3:0]    LAST_LEVEL = 4'(NUM_LEVELS - 1);

  logic [2:0]    r_state      = ST_INIT;
  logic [3:0]    r_level      = 4'd0;
  logic          r_wave_spawn = 1'b0;
  logic          r_boss_spawn = 1'b0;
  logic [GW-1:0] r_guard      = '0;
  logic [CW-1:0] r_clr_cnt    = '0;

  logic w_cleared;
  logic w_guard_done;
  logic w_clr_done;
  logic w_last_level;

  assign w_cleared    = ~|bus.fly_alive
                      & ~|bus.mosquito_alive;
  assign w_guard_done = (r_guard == GUARD_MAX);
  assign w_clr_done   = (r_clr_cnt == CLR_LAST);
  assign w_last_level = (r_level >= LAST_LEVEL);

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_level      <= 4'd0;
      r_wave_spawn <= 1'b0;
      r_boss_spawn <= 1'b0;
      r_guard      <= '0;
      r_clr_cnt    <= '0;
    end else begin
      r_wave_spawn <= 1'b0;
      r_boss_spawn <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (bus.start) begin
            r_state      <= ST_NORMAL;
            r_level      <= 4'd0;
            r_wave_spawn <= 1'b1;
            r_guard      <= '0;
          end
        end
        ST_NORMAL: begin
          if (!bus.player_alive) begin
            r_state <= ST_GAMEOVER;
          end else if (!w_guard_done) begin
            r_guard <= r_guard + GW'(1);
          end else if (w_cleared) begin
            r_guard <= '0;
            if (!w_last_level) begin
              r_level      <= r_level + 4'd1;
              r_wave_spawn <= 1'b1;
            end else begin
              r_state      <= ST_BOSS;
              r_boss_spawn <= 1'b1;
            end
          end
        end
        ST_BOSS: begin
          if (!bus.player_alive) begin
            r_state <= ST_GAMEOVER;
          end else if (!w_guard_done) begin
            r_guard <= r_guard + GW'(1);
          end else if (!bus.spider_alive) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
          end
        end
        // dwell is CLEAR_TICKS cycles counting the entry cycle
        ST_CLEAR: begin
          if (w_clr_done) begin
            r_state   <= ST_INIT;
            r_level   <= 4'd0;
            r_clr_cnt <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + CW'(1);
          end
        end
        // level stays visible as the final score until start
        ST_GAMEOVER: begin
          if (bus.start) begin
            r_state <= ST_INIT;
            r_level <= 4'd0;
          end
        end
        default: begin
          r_state   <= ST_INIT;
          r_level   <= 4'd0;
          r_guard   <= '0;
          r_clr_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.stage_state = r_state;
  assign bus.level       = r_level;
  assign bus.wave_spawn  = r_wave_spawn;
  assign bus.boss_spawn  = r_boss_spawn;

  a_spawn_excl: assert property (
    @(posedge clk25) !(r_wave_spawn && r_boss_spawn));

  a_guard_sat: assert property (
    @(posedge clk25) r_guard <= GUARD_MAX);

  a_clr_range: assert property (
    @(posedge clk25) r_clr_cnt <= CLR_LAST);

endmodule
